// File: rtl/operand_digit_register.sv
// Keypad operand register: shift-in digit buffer with held-key suppression, backspace, clear and flags.
// Optional macro DIGIT_FILTER_EN restricts accepted key codes to decimal digits 0..9.
module operand_digit_register #(
    parameter int unsigned        DIGIT_W    = 5,
    parameter int unsigned        NUM_DIGITS = 4,
    parameter logic [DIGIT_W-1:0] NO_KEY     = '1,
    localparam int unsigned       CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIGIT_W-1:0]            store,
    input  logic                          backspace,
    input  logic                          clear,
    output logic [DIGIT_W*NUM_DIGITS-1:0] read,
    output logic [CNT_W-1:0]              count,
    output logic                          loaded,
    output logic                          full,
    output logic                          overflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] slots, slots_n;
    logic [CNT_W-1:0]                   count_n;
    logic                               overflow_n;
    logic                               armed;
    logic                               is_digit;
    logic                               key_ok;

`ifdef DIGIT_FILTER_EN
    assign is_digit = (store <= DIGIT_W'(9));
`else
    assign is_digit = 1'b1;
`endif

    assign key_ok = enable && armed && (store != NO_KEY) && is_digit;
    assign read   = slots;

    always_comb begin
        slots_n    = slots;
        count_n    = count;
        overflow_n = overflow;
        if (clear) begin
            slots_n    = {NUM_DIGITS{NO_KEY}};
            count_n    = '0;
            overflow_n = 1'b0;
        end else if (backspace) begin
            // Backspace wins over a concurrent key even at count==0, where it is a no-op.
            if (count != '0) begin
                for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
                    slots_n[i] = slots[i+1];
                end
                slots_n[NUM_DIGITS-1] = NO_KEY;
                count_n               = count - CNT_W'(1);
                overflow_n            = 1'b0;
            end
        end else if (key_ok) begin
            if (count != FULL_CNT) begin
                for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
                    slots_n[i+1] = slots[i];
                end
                slots_n[0] = store;
                count_n    = count + CNT_W'(1);
            end else begin
                overflow_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slots    <= {NUM_DIGITS{NO_KEY}};
            count    <= '0;
            loaded   <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
            armed    <= 1'b1;
        end else begin
            slots    <= slots_n;
            count    <= count_n;
            loaded   <= (count_n != '0);
            full     <= (count_n == FULL_CNT);
            overflow <= overflow_n;
            armed    <= (store == NO_KEY);
        end
    end

endmodule

// File: tb/tb_operand_digit_register.sv
// Directed self-checking bench for operand_digit_register (DIGIT_W=5, NUM_DIGITS=4, NO_KEY=5'h1F).
module tb_operand_digit_register;

    localparam logic [4:0] NK = 5'h1F;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [4:0]  store;
    logic        backspace;
    logic        clear;
    logic [19:0] read;
    logic [2:0]  count;
    logic        loaded;
    logic        full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [25:0] got;
    logic [25:0] exp;

    operand_digit_register #(
        .DIGIT_W    (5),
        .NUM_DIGITS (4),
        .NO_KEY     (5'h1F)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .store     (store),
        .backspace (backspace),
        .clear     (clear),
        .read      (read),
        .count     (count),
        .loaded    (loaded),
        .full      (full),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign got = {read, count, loaded, full, overflow};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [4:0] key, input int unsigned hold);
        store = key;
        repeat (hold) step();
        store = NK;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; store = NK; backspace = 1'b0; clear = 1'b0;
        #2 reset = 1'b0;
        #1;
        exp = {20'hFFFFF, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_entry();
        enable = 1'b1;
        press(5'd1, 3);
        press(5'd2, 3);
        press(5'd3, 3);
        exp = {NK, 5'd1, 5'd2, 5'd3, 3'd3, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL held_key_entry: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_overflow();
        press(5'd4, 1);
        exp = {5'd1, 5'd2, 5'd3, 5'd4, 3'd4, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL fill_four: got %h expected %h", got, exp);
        end
        press(5'd5, 2);
        exp = {5'd1, 5'd2, 5'd3, 5'd4, 3'd4, 1'b1, 1'b1, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL overflow_set: got %h expected %h", got, exp);
        end
        backspace = 1'b1;
        step();
        backspace = 1'b0;
        exp = {NK, 5'd1, 5'd2, 5'd3, 3'd3, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backspace_after_overflow: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_backspace_priority();
        backspace = 1'b1;
        step();
        exp = {NK, NK, 5'd1, 5'd2, 3'd2, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backspace_count2: got %h expected %h", got, exp);
        end
        store = 5'd7;
        step();
        backspace = 1'b0;
        store = NK;
        step();
        exp = {NK, NK, NK, 5'd1, 3'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backspace_beats_key: got %h expected %h", got, exp);
        end
        backspace = 1'b1;
        step();
        exp = {NK, NK, NK, NK, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backspace_to_empty: got %h expected %h", got, exp);
        end
        step();
        backspace = 1'b0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backspace_at_zero: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_clear();
        press(5'd6, 1);
        exp = {NK, NK, NK, 5'd6, 3'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL key_after_empty: got %h expected %h", got, exp);
        end
        clear = 1'b1;
        store = 5'd9;
        step();
        clear = 1'b0;
        exp = {NK, NK, NK, NK, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL clear_beats_key: got %h expected %h", got, exp);
        end
        step();
        step();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL held_key_after_clear: got %h expected %h", got, exp);
        end
        store = NK;
        step();
        press(5'd9, 1);
        exp = {NK, NK, NK, 5'd9, 3'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rearm_after_clear: got %h expected %h", got, exp);
        end
        press(5'd1, 1);
        press(5'd2, 1);
        press(5'd3, 1);
        press(5'd4, 1);
        exp = {5'd9, 5'd1, 5'd2, 5'd3, 3'd4, 1'b1, 1'b1, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL overflow_before_clear: got %h expected %h", got, exp);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp = {NK, NK, NK, NK, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL clear_drops_overflow: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_filter();
        press(5'd12, 1);
`ifdef DIGIT_FILTER_EN
        exp = {NK, NK, NK, NK, 3'd0, 1'b0, 1'b0, 1'b0};
`else
        exp = {NK, NK, NK, 5'd12, 3'd1, 1'b1, 1'b0, 1'b0};
`endif
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL operator_code_12: got %h expected %h", got, exp);
        end
        enable = 1'b0;
        press(5'd8, 1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL enable_low_ignored: got %h expected %h", got, exp);
        end
        enable = 1'b1;
        press(5'd0, 1);
`ifdef DIGIT_FILTER_EN
        exp = {NK, NK, NK, 5'd0, 3'd1, 1'b1, 1'b0, 1'b0};
`else
        exp = {NK, NK, 5'd12, 5'd0, 3'd2, 1'b1, 1'b0, 1'b0};
`endif
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL digit_zero_accepted: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_entry();
        press(5'd3, 1);
        #2 reset = 1'b0;
        #1;
        exp = {20'hFFFFF, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset_mid_entry: got %h expected %h", got, exp);
        end
        step();
        reset = 1'b1;
        press(5'd5, 1);
        exp = {NK, NK, NK, 5'd5, 3'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL entry_after_reset: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_entry();
        test_overflow();
        test_backspace_priority();
        test_clear();
        test_filter();
        test_reset_mid_entry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
